// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the multi-channel 2D convolution engine.
// Output dimension and accumulator width are derived here so that the engine and
// its bus interface agree on every array shape.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // Number of valid (unpadded) window positions along one axis.
  function automatic int out_dim(input int n, input int k, input int stride);
    return (n - k) / stride + 1;
  endfunction

  // Unsigned pixel times signed coefficient needs 2*dw+1 bits; summing c*k*k of
  // them needs clog2(c*k*k) more, so the accumulator can never overflow.
  function automatic int acc_width(input int dw, input int c, input int k);
    return 2 * dw + 1 + $clog2(c * k * k);
  endfunction

  // Index width for a counter over n positions, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_mc_engine_if.sv
// Block-level bus of the convolution engine: run request, operands, status and results.
// The caller (master) drives the request and operands; the engine (slave) drives status
// and the result array, which it holds until the next accepted start.
interface conv2d_mc_engine_if #(
  parameter int N      = 5,
  parameter int K      = 3,
  parameter int C      = 1,
  parameter int STRIDE = 1,
  parameter int DW     = 8
);
  localparam int M     = conv_pkg::out_dim(N, K, STRIDE);
  localparam int ACC_W = conv_pkg::acc_width(DW, C, K);

  logic                                   start;
  logic                                   relu_en;
  logic [C-1:0][N-1:0][N-1:0][DW-1:0]     image;
  logic [C-1:0][K-1:0][K-1:0][DW-1:0]     kernel;
  logic                                   busy;
  logic                                   done;
  logic [M-1:0][M-1:0][ACC_W-1:0]         result;

  modport master (
    output start, relu_en, image, kernel,
    input  busy, done, result
  );

  modport slave (
    input  start, relu_en, image, kernel,
    output busy, done, result
  );
endinterface

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate: unsigned pixel times signed coefficient.
// One product per enabled cycle; the sum is visible the cycle after the enable.
// Clear takes priority over enable; no backpressure, the controller paces it.
module conv_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DW-1:0]           pix_i,
  input  logic [DW-1:0]           coef_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW:0]    pix_s;
  logic signed [2*DW:0]    coef_s;
  logic signed [2*DW:0]    prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Pixel is zero-extended, coefficient sign-extended; the true product always
  // fits in 2*DW+1 bits so the truncated multiply is exact.
  assign pix_s  = {{(DW + 1){1'b0}}, pix_i};
  assign coef_s = {{(DW + 1){coef_i[DW-1]}}, coef_i};
  assign prod   = pix_s * coef_s;

  // Next accumulator value: clear wins so a window restarts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv2d_mc_engine.sv
// Valid 2D convolution of a C-channel NxN image with a C-channel KxK kernel, optional ReLU.
// Latency M*M*(C*K*K+1) cycles from the accepting edge to the last writeback; done follows.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped.
module conv2d_mc_engine
  import conv_pkg::*;
#(
  parameter int N      = 5,
  parameter int K      = 3,
  parameter int C      = 1,
  parameter int STRIDE = 1,
  parameter int DW     = 8
) (
  input logic               clk,
  input logic               rst_n,
  conv2d_mc_engine_if.slave bus
);

  localparam int M     = out_dim(N, K, STRIDE);
  localparam int ACC_W = acc_width(DW, C, K);
  localparam int NW    = idx_width(N);
  localparam int KW    = idx_width(K);
  localparam int CW    = idx_width(C);
  localparam int MW    = idx_width(M);

  if (N < K) begin : g_chk_nk
    $error("conv2d_mc_engine: N must be >= K");
  end
  if (K < 1 || C < 1 || STRIDE < 1) begin : g_chk_pos
    $error("conv2d_mc_engine: K, C and STRIDE must be >= 1");
  end

  conv_state_t state_q, state_d;

  logic [C-1:0][N-1:0][N-1:0][DW-1:0] img_q;
  logic [C-1:0][K-1:0][K-1:0][DW-1:0] ker_q;
  logic                               relu_q;
  logic [M-1:0][M-1:0][ACC_W-1:0]     res_q;

  logic [MW-1:0] oy_q, oy_d, ox_q, ox_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;

  logic capture, mac_en, mac_clr, wr_en;

  logic [NW-1:0]           row, col;
  logic [DW-1:0]           pix, coef;
  logic signed [ACC_W-1:0] acc;

  // Current tap: image position of this window/kernel element and its coefficient.
  assign row  = NW'(32'(oy_q) * STRIDE + 32'(ky_q));
  assign col  = NW'(32'(ox_q) * STRIDE + 32'(kx_q));
  assign pix  = img_q[c_q][row][col];
  assign coef = ker_q[c_q][ky_q][kx_q];

  conv_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .pix_i  (pix),
    .coef_i (coef),
    .acc_o  (acc)
  );

  // Next-state and control: walk kx, then ky, then channel; one writeback per window.
  always_comb begin
    state_d = state_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    c_d     = c_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    capture = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          mac_clr = 1'b1;
          oy_d    = '0;
          ox_d    = '0;
          c_d     = '0;
          ky_d    = '0;
          kx_d    = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(K - 1)) begin
            ky_d = '0;
            if (c_q == CW'(C - 1)) begin
              c_d     = '0;
              state_d = WRITE;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            ky_d = ky_q + KW'(1);
          end
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        mac_clr = 1'b1;
        state_d = MAC;
        if (ox_q == MW'(M - 1)) begin
          ox_d = '0;
          if (oy_q == MW'(M - 1)) begin
            oy_d    = '0;
            state_d = DONE;
          end else begin
            oy_d = oy_q + MW'(1);
          end
        end else begin
          ox_d = ox_q + MW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, indices and operands captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oy_q    <= '0;
      ox_q    <= '0;
      c_q     <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      img_q   <= '0;
      ker_q   <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      c_q     <= c_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      if (capture) begin
        img_q  <= bus.image;
        ker_q  <= bus.kernel;
        relu_q <= bus.relu_en;
      end
    end
  end

  // Writeback of the finished window, clamped to zero when ReLU is on and the sum is negative.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (wr_en) begin
      res_q[oy_q][ox_q] <= (relu_q && acc[ACC_W-1]) ? '0 : acc;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;

endmodule

// File: doc/conv2d_mc_engine.md
Name: conv2d_mc_engine

Overview:
Parametrised multi-channel successor to convolution2D. It performs a valid (unpadded) 2D convolution of a C-channel N×N image with a C-channel K×K kernel, using a configurable stride. Channels are summed into each output, and an optional ReLU is applied at writeback. It uses one sequential multiply-accumulate per cycle and the same start/done block handshake as convolution2D. It sits between the image buffer and the MaxNet layer logic.

Parameters:
N, 5, image height/width; N >= K (elaboration-time assertion).
K, 3, kernel height/width; K >= 1.
C, 1, channel count; C >= 1.
STRIDE, 1, window step in both dimensions; STRIDE >= 1.
DW, 8, pixel and kernel-coefficient width.
M (localparam), (N-K)/STRIDE+1 (floor), output dimension.
ACC_W (localparam), 2*DW+1+$clog2(C*K*K), accumulator and result width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; synchronous, active-low.
start  input  1  run request; level-sampled in IDLE only.
relu_en  input  1  clamp negative results to 0; captured on accepted start.
image  input  [C][N][N]×DW  unsigned pixels; captured on accepted start.
kernel  input  [C][K][K]×DW  signed (two's complement) coefficients; captured on accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when all results are valid.
result  output  [M][M]×ACC_W  signed outputs; held until next accepted start.

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE; busy=0; done=0; all result entries=0; accumulator and indices=0. Reset mid-run aborts the run immediately with no partial completion.
- IDLE: start=1 captures image/kernel/relu_en into internal registers, clears acc and indices (oy,ox,c,ky,kx), then goes to MAC. Inputs may change freely after the capture edge.
- MAC: each cycle, acc += $signed({1'b0,img_r[c][oy*S+ky][ox*S+kx]}) * kernel_r[c][ky][kx].
  - Product is 2*DW+1 bits, sign-extended to ACC_W; overflow is impossible by construction.
  - Index order: kx fastest, then ky, then c.
  - After the C*K*K-th product, go to WRITE.
- WRITE: result[oy][ox] <= (relu_en_r && acc<0) ? 0 : acc; acc cleared; ox advances, wrapping into oy. Last window (oy=ox=M-1) goes to DONE, otherwise back to MAC.
- DONE: done=1 for exactly this cycle; next state IDLE. All results are stable and valid when done is high.
- Latency: T = M*M*(C*K*K+1) cycles from the accepting edge to the last WRITE edge. done is high during cycle T+1.
- start while busy: ignored, no queueing.
- start still high in the IDLE cycle after DONE: starts a new run. Callers drop start on done.
- result entries update one at a time during a run. Entries not yet rewritten keep their previous-run values.

Decomposition:
- Package conv_pkg:
  - function out_dim(N,K,STRIDE)
  - function acc_width(DW,C,K)
  - typedef enum {IDLE, MAC, WRITE, DONE} conv_state_t
- One sub-module, conv_mac: registered signed multiply-accumulate with clear and enable, parametrised by DW and ACC_W.
- Window indexing and the FSM stay in conv2d_mc_engine.

Test Plan:
1. Baseline (N=5,K=3,C=1,S=1,relu_en=0).
   - Stimulus: image rows {0,1,2,3,3},{4,5,6,7,7},{8,9,10,11,11},{12,13,14,15,15},{0,1,2,3,3}; kernel 0..8 row-major.
   - Expect: result[0][0]=258, [0][1]=294, [0][2]=315.
   - Expect: done pulses exactly 1 cycle, high in cycle 91 after the start edge.
2. Stride 2 (S=2, same data).
   - Expect: M=2; result [0][0]=258, [0][1]=315, [1][0]=210, [1][1]=267.
   - Expect: done in cycle 41.
3. Signed kernel and ReLU.
   - Stimulus: image all 8'h10, kernel all 8'hFF.
   - Expect: with relu_en=0, all results = -144. With relu_en=1, all results = 0.
4. Multi-channel (C=2), both channels set to the scenario-1 data.
   - Expect: result[0][0]=516, [0][2]=630.
   - Expect: done in cycle 9*(18+1)+1 = 172.
5. Handshake.
   - Stimulus: pulse start again mid-run, and change image mid-run.
   - Expect: both ignored; results match scenario 1; busy high from the start edge through the DONE cycle.
6. Reset mid-MAC.
   - Stimulus: drop rst_n for 1 cycle.
   - Expect: next cycle busy=0, done=0, all results 0; a following start gives scenario-1 results.
